ped_crossing_ctrl: RTL and testbench
====================================

# ped_crossing_ctrl

Pedestrian-side controller for the intersection: it is the counterpart of the vehicle stoplight FSM on the `Ped`/`SigG`/`SigY`/`SigR` interface. It debounces the raw crosswalk button and holds the `Ped` request to the stoplight until the request is served. It watches the vehicle signals and drives the WALK / DON'T WALK lamps with a timed walk interval, a flashing clearance interval and a countdown. Any loss of vehicle red, or an illegal vehicle-signal combination, forces DON'T WALK immediately.

## Interface
- `DB_CYCLES`, 4: consecutive stable cycles required to change the debounced button level (1..255).
- `WALK_CYCLES`, 8: length of the WALK interval in clock cycles (1..255).
- `CLEAR_CYCLES`, 6: length of the flashing clearance interval (1..15).
- `FLASH_DIV`, 2: cycles per flash half-period during clearance (≥1).

Ports:
- `clock` input, 1: single system clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-high; returns the block to the reset state immediately.
- `Button` input, 1: raw, asynchronous, bouncing push-button.
- `SigG` input, 1: vehicle green lamp.
- `SigY` input, 1: vehicle yellow lamp.
- `SigR` input, 1: vehicle red lamp.
- `Ped` output, 1: registered crossing request to the stoplight.
- `Walk` output, 1: WALK lamp.
- `DontWalk` output, 1: DON'T WALK lamp; solid or flashing.
- `Count` output, 4: clearance countdown display; 0 outside clearance.
- `Fault` output, 1: registered; high while the vehicle signals are not exactly one-hot.

## Operation
- **Input path.** `Button` passes through a 2-flop synchronizer, then the debouncer. The debounced level changes only after the synchronized value has differed from it for `DB_CYCLES` consecutive cycles. Any mismatch gap restarts the count. A press event is a debounced 0→1 transition.
- **Request.** The request register drives `Ped`.
  - It is set by a press event in any state.
  - It is cleared on the WAIT_RED→WALK transition.
  - If a set and a clear fall on the same edge, the set wins.
- **Red-OK.** Red-OK means `SigR`=1, `SigG`=0, `SigY`=0.
- **States.** IDLE, WAIT_RED, WALK, CLEAR.
  - IDLE: `Walk`=0, `DontWalk`=1 solid. Goes to WAIT_RED when the request is set.
  - WAIT_RED: same lamps as IDLE. Goes to WALK on the first edge at which Red-OK is sampled.
  - WALK: `Walk`=1, `DontWalk`=0 for exactly `WALK_CYCLES` cycles, then goes to CLEAR.
  - CLEAR: `Walk`=0 for exactly `CLEAR_CYCLES` cycles. `DontWalk` is 1 for `FLASH_DIV` cycles, then 0 for `FLASH_DIV` cycles, repeating, starting at 1. `Count` shows `CLEAR_CYCLES` on the first CLEAR cycle and decrements to 1 on the last.
  - CLEAR exit: goes to WAIT_RED if the request is set, otherwise to IDLE.
- **Abort.** In WALK or CLEAR, if Red-OK is false at a sampling edge, the next state is IDLE, or WAIT_RED if the request is set. The lamps go to `Walk`=0, `DontWalk`=1 solid, `Count`=0 at that same edge.
- **Fault.** `Fault` is registered as NOT one-hot(`SigG`,`SigY`,`SigR`). It never blocks request latching.
- **Reset.** All registers return to the reset state: IDLE, request=0, synchronizer and debouncer at 0, timers at 0, `Ped`=0, `Walk`=0, `DontWalk`=1, `Count`=0, `Fault`=0.
  - Reset mid-WALK drops `Walk` asynchronously.
  - A press in progress is discarded.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Press latency: number the first edge sampling `Button`=1 as edge 1 and hold the button. The debounced level rises at edge `DB_CYCLES`+2. `Ped` rises at edge `DB_CYCLES`+3, which is edge 7 at the defaults.
- Walk latency: with Red-OK already true, WALK starts on the edge after `Ped` rises. `Ped` falls on that same edge.
- Interval lengths are exact. WALK is `WALK_CYCLES` cycles. CLEAR is `CLEAR_CYCLES` cycles. The timers reload on state entry.
- `Fault` lags the signal inputs by one cycle.
- A press event on the final CLEAR cycle is honored: the exit goes to WAIT_RED.

## Test plan
- **Reset values.** Assert `reset` mid-cycle → outputs are `Ped`=0, `Walk`=0, `DontWalk`=1, `Count`=0, `Fault`=0 without waiting for a clock edge.
- **Bounce rejection.** Pulse `Button` high for 3 cycles with `DB_CYCLES`=4 → `Ped` never asserts. Hold it 10 cycles → `Ped`=1 at edge 7.
- **Full cycle.** Start with `SigG`=1 and press. `Ped` stays 1 until `SigR` is one-hot. Then `Walk`=1 for 8 cycles, `Ped`=0. Then 6 CLEAR cycles with `Count` 6,5,4,3,2,1 and `DontWalk` 1,1,0,0,1,1. Then IDLE.
- **Abort.** Drive `SigG`=1 on the 3rd WALK cycle → `Walk`=0, `DontWalk`=1 solid, `Count`=0 on that edge, then IDLE.
- **Re-request.** Press during WALK → `Ped` rises during WALK. After CLEAR the state is WAIT_RED, and WALK starts again while red holds.
- **Fault.** Drive `SigR`=`SigG`=1 → `Fault`=1 one cycle later. Any WALK in progress aborts. Drive `SigR` alone again → `Fault`=0 next cycle.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounces the crosswalk button, requests a
// crossing from the vehicle stoplight and sequences the WALK / DON'T WALK lamps.
module ped_crossing_ctrl #(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned CLEAR_CYCLES = 6,
  parameter int unsigned FLASH_DIV    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Button,
  input  logic       SigG,
  input  logic       SigY,
  input  logic       SigR,
  output logic       Ped,
  output logic       Walk,
  output logic       DontWalk,
  output logic [3:0] Count,
  output logic       Fault
);

  localparam int unsigned DB_W  = 8;
  localparam int unsigned TMR_W = 8;
  localparam int unsigned FL_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RED,
    S_WALK,
    S_CLEAR
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_db;
  logic              r_db_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_req;
  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [FL_W-1:0]   r_flash_cnt;
  logic              r_walk;
  logic              r_dont_walk;
  logic [3:0]        r_count;
  logic              r_fault;

  logic              w_press;
  logic              w_red_ok;
  logic              w_one_hot;
  logic              w_req_nxt;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [FL_W-1:0]   w_flash_nxt;
  logic              w_walk_nxt;
  logic              w_dw_nxt;
  logic [3:0]        w_count_nxt;

  assign w_press   = r_db & ~r_db_d;
  assign w_red_ok  = SigR & ~SigG & ~SigY;
  assign w_one_hot = ({SigG, SigY, SigR} == 3'b100) ||
                     ({SigG, SigY, SigR} == 3'b010) ||
                     ({SigG, SigY, SigR} == 3'b001);
  // A press on the same edge as the WAIT_RED->WALK clear keeps the request.
  assign w_req_nxt = w_press | (r_req & ~((r_state == S_WAIT_RED) & w_red_ok));

  // Synchronizer, debouncer and press-edge detector
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db     <= 1'b0;
      r_db_d   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= Button;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
          r_db     <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // State, timers and registered lamp outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_flash_cnt <= '0;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_count     <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_req       <= w_req_nxt;
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_flash_cnt <= w_flash_nxt;
      r_walk      <= w_walk_nxt;
      r_dont_walk <= w_dw_nxt;
      r_count     <= w_count_nxt;
      r_fault     <= ~w_one_hot;
    end
  end

  // Next state; lamp values are computed for the state being entered
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_flash_nxt = r_flash_cnt;
    w_walk_nxt  = 1'b0;
    w_dw_nxt    = 1'b1;
    w_count_nxt = 4'd0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_nxt) w_state_nxt = S_WAIT_RED;
      end
      S_WAIT_RED: begin
        if (w_red_ok) begin
          w_state_nxt = S_WALK;
          w_timer_nxt = TMR_W'(WALK_CYCLES - 1);
          w_walk_nxt  = 1'b1;
          w_dw_nxt    = 1'b0;
        end
      end
      S_WALK: begin
        if (!w_red_ok) begin
          w_state_nxt = w_req_nxt ? S_WAIT_RED : S_IDLE;
        end else if (r_timer == '0) begin
          w_state_nxt = S_CLEAR;
          w_timer_nxt = TMR_W'(CLEAR_CYCLES - 1);
          w_flash_nxt = '0;
          w_count_nxt = 4'(CLEAR_CYCLES);
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
          w_walk_nxt  = 1'b1;
          w_dw_nxt    = 1'b0;
        end
      end
      S_CLEAR: begin
        if (!w_red_ok || r_timer == '0) begin
          w_state_nxt = w_req_nxt ? S_WAIT_RED : S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
          w_count_nxt = 4'(r_timer);
          if (r_flash_cnt == FL_W'(FLASH_DIV - 1)) begin
            w_flash_nxt = '0;
            w_dw_nxt    = ~r_dont_walk;
          end else begin
            w_flash_nxt = r_flash_cnt + FL_W'(1);
            w_dw_nxt    = r_dont_walk;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign Ped      = r_req;
  assign Walk     = r_walk;
  assign DontWalk = r_dont_walk;
  assign Count    = r_count;
  assign Fault    = r_fault;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl at default parameters; outputs are
// checked as the vector {Ped, Walk, DontWalk, Count, Fault} #1 after each edge.
module tb_ped_crossing_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       Button;
  logic       SigG;
  logic       SigY;
  logic       SigR;
  logic       Ped;
  logic       Walk;
  logic       DontWalk;
  logic [3:0] Count;
  logic       Fault;

  int checks   = 0;
  int failures = 0;

  logic [5:0] dwpat = 6'b110011;

  always #5 clock = ~clock;

  ped_crossing_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .Button   (Button),
    .SigG     (SigG),
    .SigY     (SigY),
    .SigR     (SigR),
    .Ped      (Ped),
    .Walk     (Walk),
    .DontWalk (DontWalk),
    .Count    (Count),
    .Fault    (Fault)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] v(input logic p, input logic w, input logic d,
                                   input logic [3:0] c, input logic f);
    return {p, w, d, c, f};
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {Ped, Walk, DontWalk, Count, Fault};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (Ped,Walk,DontWalk,Count[3:0],Fault)",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    Button = 1'b0;
    SigG   = 1'b1;
    SigY   = 1'b0;
    SigR   = 1'b0;
    #3;
    check("reset_init", v(0, 0, 1, 4'd0, 0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tick;
    check("idle", v(0, 0, 1, 4'd0, 0));

    // Three-cycle bounce must be rejected
    Button = 1'b1;
    repeat (3) tick;
    Button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      check("bounce", v(0, 0, 1, 4'd0, 0));
    end

    // Held press: Ped rises at edge 7; vehicle green keeps it waiting
    Button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      check("press_ped", (i >= 7) ? v(1, 0, 1, 4'd0, 0) : v(0, 0, 1, 4'd0, 0));
    end
    Button = 1'b0;
    repeat (8) tick;
    check("wait_red_hold", v(1, 0, 1, 4'd0, 0));

    // Full cycle once red is one-hot
    SigG = 1'b0;
    SigR = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check("walk", v(0, 1, 0, 4'd0, 0));
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      check("clear", v(0, 0, dwpat[5-i], 4'(6 - i), 0));
    end
    tick;
    check("idle_after_clear", v(0, 0, 1, 4'd0, 0));

    // Abort on the 3rd WALK cycle
    Button = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check("abort_press", (i == 7) ? v(1, 0, 1, 4'd0, 0) : v(0, 0, 1, 4'd0, 0));
    end
    Button = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("abort_walk", v(0, 1, 0, 4'd0, 0));
    end
    SigG = 1'b1;
    SigR = 1'b0;
    tick;
    check("abort", v(0, 0, 1, 4'd0, 0));
    tick;
    check("abort_idle", v(0, 0, 1, 4'd0, 0));
    SigG = 1'b0;
    SigR = 1'b1;
    repeat (3) tick;
    check("abort_stays_idle", v(0, 0, 1, 4'd0, 0));

    // Re-request during WALK, returning through WAIT_RED
    SigG   = 1'b1;
    SigR   = 1'b0;
    Button = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check("rr_press", (i == 7) ? v(1, 0, 1, 4'd0, 0) : v(0, 0, 1, 4'd0, 0));
    end
    Button = 1'b0;
    repeat (8) tick;
    check("rr_wait", v(1, 0, 1, 4'd0, 0));
    SigG   = 1'b0;
    SigR   = 1'b1;
    Button = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check("rr_walk", v((i >= 7), 1, 0, 4'd0, 0));
    end
    Button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rr_clear", v(1, 0, dwpat[5-i], 4'(6 - i), 0));
    end
    tick;
    check("rr_wait_red", v(1, 0, 1, 4'd0, 0));
    tick;
    check("rr_walk_again", v(0, 1, 0, 4'd0, 0));

    // Illegal signal combination aborts WALK and raises Fault
    tick;
    check("walk_before_fault", v(0, 1, 0, 4'd0, 0));
    SigG = 1'b1;
    tick;
    check("fault_abort", v(0, 0, 1, 4'd0, 1));
    tick;
    check("fault_hold", v(0, 0, 1, 4'd0, 1));
    SigG = 1'b0;
    tick;
    check("fault_clear", v(0, 0, 1, 4'd0, 0));

    // Fault does not block the request
    SigY   = 1'b1;
    Button = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check("fault_press", (i == 7) ? v(1, 0, 1, 4'd0, 1) : v(0, 0, 1, 4'd0, 1));
    end
    Button = 1'b0;
    SigY   = 1'b0;
    tick;
    check("fault_walk", v(0, 1, 0, 4'd0, 0));

    // Asynchronous reset in the middle of WALK
    #3;
    reset = 1'b1;
    #1;
    check("reset_async", v(0, 0, 1, 4'd0, 0));
    #10;
    reset = 1'b0;
    tick;
    check("post_reset", v(0, 0, 1, 4'd0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
